// File: rtl/muldiv_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int MDOp_WIDTH = 3
);
  logic                  Start;
  logic [0:MDOp_WIDTH-1] MDOp;
  logic [0:31]           A;
  logic [0:31]           B;
  logic                  Flush;
  logic                  Busy;
  logic                  Done;
  logic [0:31]           Result;
  logic                  Ovf;

  modport master (
    output Start, MDOp, A, B, Flush,
    input  Busy, Done, Result, Ovf
  );

  modport slave (
    input  Start, MDOp, A, B, Flush,
    output Busy, Done, Result, Ovf
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider for the EX stage.
// One product or quotient bit per cycle; sign handled on magnitudes.
module muldiv_unit #(
  parameter int MDOp_WIDTH = 3,
  parameter int ITER       = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(ITER) + 1;

  localparam logic [MDOp_WIDTH-1:0] OP_MUL_LO   = MDOp_WIDTH'(0);
  localparam logic [MDOp_WIDTH-1:0] OP_MUL_HI_S = MDOp_WIDTH'(1);
  localparam logic [MDOp_WIDTH-1:0] OP_MUL_HI_U = MDOp_WIDTH'(2);
  localparam logic [MDOp_WIDTH-1:0] OP_DIV_S    = MDOp_WIDTH'(3);
  localparam logic [MDOp_WIDTH-1:0] OP_DIV_U    = MDOp_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [MDOp_WIDTH-1:0] op_q, op_d;
  logic                  sign_q, sign_d;
  logic [31:0]           mcand_q, mcand_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           res_q, res_d;
  logic                  ovf_q, ovf_d;

  logic [MDOp_WIDTH-1:0] op_in;
  logic [31:0]           a_in, b_in;
  logic [31:0]           a_mag, b_mag;
  logic                  op_valid, is_div_in, signed_in, special;
  logic                  is_div_q;

  logic [32:0]           sum;
  logic [31:0]           mul_hi, mul_lo;
  logic [32:0]           sh, diff;
  logic [31:0]           div_hi, div_lo;
  logic [31:0]           neg_hi;
  logic [31:0]           fix_res;

  assign op_in = bus.MDOp;
  assign a_in  = bus.A;
  assign b_in  = bus.B;

  assign op_valid  = (op_in <= OP_DIV_U);
  assign is_div_in = (op_in == OP_DIV_S) || (op_in == OP_DIV_U);
  assign signed_in = (op_in == OP_MUL_HI_S) || (op_in == OP_DIV_S);
  assign a_mag     = (signed_in && a_in[31]) ? -a_in : a_in;
  assign b_mag     = (signed_in && b_in[31]) ? -b_in : b_in;

  assign special = is_div_in &&
                   ((b_in == 32'd0) ||
                    ((op_in == OP_DIV_S) &&
                     (a_in == 32'h8000_0000) &&
                     (b_in == 32'hFFFF_FFFF)));

  assign is_div_q = (op_q == OP_DIV_S) || (op_q == OP_DIV_U);

  // Multiply: {hi,lo} shifts right, multiplier drains out of lo.
  assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign mul_hi = sum[32:1];
  assign mul_lo = {sum[0], lo_q[31:1]};

  // Divide: dividend shifts out of lo into the remainder in hi.
  assign sh     = {hi_q, lo_q[31]};
  assign diff   = sh - {1'b0, mcand_q};
  assign div_hi = diff[32] ? sh[31:0] : diff[31:0];
  assign div_lo = {lo_q[30:0], ~diff[32]};

  // High word of -{hi,lo}: carry into hi only when lo is zero.
  assign neg_hi = ~hi_q + {31'd0, (lo_q == 32'd0)};

  always_comb begin
    fix_res = lo_q;
    unique case (1'b1)
      (op_q == OP_MUL_HI_S): fix_res = sign_q ? neg_hi : hi_q;
      (op_q == OP_MUL_HI_U): fix_res = hi_q;
      (op_q == OP_DIV_S):    fix_res = sign_q ? -lo_q : lo_q;
      default:               fix_res = lo_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sign_d  = sign_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Flush && op_valid) begin
          op_d    = op_in;
          sign_d  = signed_in && (a_in[31] ^ b_in[31]);
          mcand_d = is_div_in ? b_mag : a_mag;
          lo_d    = is_div_in ? a_mag : b_mag;
          hi_d    = 32'd0;
          cnt_d   = '0;
          if (special) begin
            res_d   = 32'd0;
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            ovf_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.Flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = is_div_q ? div_hi : mul_hi;
          lo_d  = is_div_q ? div_lo : mul_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        if (bus.Flush) begin
          state_d = S_IDLE;
        end else begin
          res_d   = fix_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sign_q  <= 1'b0;
      mcand_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= '0;
      res_q   <= 32'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.Done   = (state_q == S_DONE);
  assign bus.Result = res_q;
  assign bus.Ovf    = ovf_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Vector table plus scoreboard bench for muldiv_unit.
// Hand sequences cover flush, ignored start and mid-op reset.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.MDOp_WIDTH(3)) bus ();

  muldiv_unit #(
    .MDOp_WIDTH(3),
    .ITER(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t sbq[$];
  logic [31:0] last_res = 32'd0;
  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t r;
    longint sa;
    longint sb;
    logic [63:0] p;
    r.res = 32'd0;
    r.ovf = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r.res = p[31:0]; end
      3'd1: begin p = sa * sb; r.res = p[63:32]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; r.res = p[63:32]; end
      3'd3: begin
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
          r.ovf = 1'b1;
        else
          r.res = 32'($signed(a) / $signed(b));
      end
      3'd4: begin
        if (b == 32'd0) r.ovf = 1'b1;
        else r.res = a / b;
      end
      default: ;
    endcase
    r.lat = r.ovf ? 1 : 34;
    return r;
  endfunction

  task automatic drive_start(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.MDOp = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1 bus.Start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bn, output bit got);
    n = 0;
    bn = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (bus.Busy) bn++;
      if (bus.Done) got = 1'b1;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eres,
                        input logic eovf);
    exp_t e;
    exp_t x;
    int n;
    int bn;
    bit got;
    e.res = eres;
    e.ovf = eovf;
    e.lat = eovf ? 1 : 34;
    sbq.push_back(e);
    drive_start(op, a, b);
    wait_done(n, bn, got);
    x = sbq.pop_front();
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("result", bus.Result, x.res);
      check("ovf", 32'(bus.Ovf), 32'(x.ovf));
      check("latency", 32'(n), 32'(x.lat));
      check("busy_cycles", 32'(bn), (x.lat == 34) ? 32'd33 : 32'd0);
    end
    last_res = x.res;
  endtask

  initial begin
    int dcnt;
    int first;
    logic [31:0] dres;
    logic [2:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    exp_t m;

    vt[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vt[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vt[2]  = '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vt[3]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vt[4]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vt[5]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 1'b0};
    vt[6]  = '{3'd4, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[7]  = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0};
    vt[8]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vt[9]  = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0};
    vt[10] = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vt[11] = '{3'd3, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vt[12] = '{3'd4, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
    vt[13] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vt[14] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[15] = '{3'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    bus.MDOp = 3'd0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_result", bus.Result, 32'd0);
    check("rst_ovf", 32'(bus.Ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reserved opcode must not start anything.
    drive_start(3'd5, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    check("reserved_busy", 32'(bus.Busy), 32'd0);
    check("reserved_done", 32'(bus.Done), 32'd0);

    for (int i = 0; i < 16; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].ovf);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      m = model(rop, ra, rb);
      run_op(rop, ra, rb, m.res, m.ovf);
    end

    // Flush mid-CALC: no Done, Result keeps the previous value.
    drive_start(3'd0, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    bus.Flush = 1'b1;
    @(posedge clk);
    #1 bus.Flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(bus.Busy), 32'd0);
    check("flush_done", 32'(bus.Done), 32'd0);
    check("flush_result", bus.Result, last_res);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done) dcnt++;
    end
    check("flush_no_done", 32'(dcnt), 32'd0);

    // Start during CALC is dropped; exactly one Done.
    drive_start(3'd4, 32'd100, 32'd7);
    dcnt = 0;
    first = 0;
    dres = 32'd0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.Start = 1'b1;
        bus.MDOp = 3'd0;
      end
      if (i == 6) bus.Start = 1'b0;
      if (bus.Done) begin
        dcnt++;
        if (first == 0) begin
          first = i;
          dres = bus.Result;
        end
      end
    end
    check("ignored_start_dones", 32'(dcnt), 32'd1);
    check("ignored_start_lat", 32'(first), 32'd34);
    check("ignored_start_result", dres, 32'd14);
    check("ignored_start_idle", 32'(bus.Busy), 32'd0);

    // Reset mid-CALC clears all outputs.
    drive_start(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_done", 32'(bus.Done), 32'd0);
    check("midrst_result", bus.Result, 32'd0);
    check("midrst_ovf", 32'(bus.Ovf), 32'd0);

    run_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b0);
    run_op(3'd4, 32'd0, 32'd0, 32'd0, 1'b1);
    run_op(3'd3, 32'hFFFF_FF9C, 32'd10, 32'hFFFF_FFF6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the EX stage. It executes mullw, mulli, mulhw, mulhwu, divw and divwu.
- Operand B arrives already selected by the EX operand mux, either rB or the 32-bit sign-extended immediate (mulli). No immediate handling happens inside this block.
- The pipeline control stalls while Busy is high and writes back Result on the Done pulse.

Parameters:
- MDOp_WIDTH, 3, width of the operation select.
- ITER, 32, iteration count of the shift-add / restoring-divide core. Fixed to the data width; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- Start  input  1  request. Sampled only in IDLE.
- MDOp  input  [0:MDOp_WIDTH-1]  operation: 0 MUL_LO, 1 MUL_HI_S, 2 MUL_HI_U, 3 DIV_S, 4 DIV_U, 5-7 reserved.
- A  input  [0:31]  operand rA (bit 0 = MSB).
- B  input  [0:31]  operand rB or extended immediate.
- Flush  input  1  abort current operation.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle completion pulse.
- Result  output  [0:31]  result, valid when Done=1 and held until the next accepted Start.
- Ovf  output  1  divide overflow (divisor 0, or 0x80000000 / -1 for DIV_S). Valid with Done, held like Result.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; Busy=0, Done=0, Result=0, Ovf=0; all internal registers cleared. Reset overrides Start and Flush, including mid-operation.
- States:
  - IDLE: waiting for a request.
  - CALC: ITER iterations.
  - FIX: sign correction and result select.
  - DONE: Done pulse.
- IDLE:
  - Start=1 with MDOp in 0-4: latch A, B and MDOp.
  - Signed ops (1, 3): latch magnitudes |A| and |B| and the result sign (A[0]^B[0]).
  - Divide special case: DIV_U/DIV_S with B=0, or DIV_S with A=0x80000000 and B=0xFFFFFFFF. Go directly to DONE with Result=0 and Ovf=1.
  - Otherwise go to CALC with iteration counter=0 and Ovf cleared.
  - Reserved MDOp: Start is ignored and the state stays IDLE.
- CALC:
  - Multiply: radix-2 shift-add into a 64-bit product register, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle. The remainder is kept internally and never output.
  - Leaves to FIX after exactly ITER cycles.
- FIX:
  - MUL_LO takes the low word of the unsigned product; this is correct for signed operands, so no correction is applied.
  - MUL_HI_S takes the high word of the 64-bit two's-complement negation when the sign bit is set, otherwise the high word.
  - MUL_HI_U takes the high word.
  - DIV_S takes the quotient negated when the sign bit is set, truncating toward zero.
  - DIV_U takes the quotient.
  - Result is registered here.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Timing:
  - Busy=1 in CALC and FIX, and 0 in IDLE and DONE.
  - Normal latency: Start sampled at edge T0, Done high in the cycle after edge T0+ITER+2, i.e. 34 cycles for ITER=32.
  - Special-case latency: Done high in the cycle after edge T0+1.
- Start during CALC, FIX or DONE: ignored and never queued. A new Start may be accepted in the cycle after Done.
- Flush=1 in any non-IDLE state: next state IDLE, Busy=0, no Done pulse, Result and Ovf keep their previous values. Flush in IDLE has no effect, and Flush has priority over Start in the same cycle.

Test Plan:
- MUL_LO, A=0x00000007, B=0xFFFFFFFD (mulli -3) -> Done after 34 cycles, Result=0xFFFFFFEB, Ovf=0, Busy high for 33 cycles.
- MUL_HI_S, A=0x80000000, B=0x80000000 -> Result=0x40000000; MUL_HI_U with the same operands -> Result=0x40000000; MUL_HI_S with A=0xFFFFFFFF, B=0x00000002 -> Result=0xFFFFFFFF.
- DIV_S, A=0xFFFFFFF9 (-7), B=0x00000002 -> Result=0xFFFFFFFD (-3); DIV_U, A=0xFFFFFFF9, B=0x00000002 -> Result=0x7FFFFFFC.
- DIV_U with B=0 -> Done in the cycle after edge T0+1, Result=0, Ovf=1; DIV_S with A=0x80000000, B=0xFFFFFFFF -> same response; a following valid op clears Ovf.
- Flush at iteration 10 of a MUL_LO -> IDLE the next cycle, no Done, Result still holds the prior value; Start asserted at iteration 5 of another op -> ignored, exactly one Done.
- rst_n=0 for one edge mid-CALC -> all outputs 0 the next cycle; back-to-back Start in the cycle after Done -> accepted.
